// File: rtl/sdr_req_arbiter.sv
// ============================================================================
// Module   : sdr_req_arbiter
// Purpose  : Round-robin arbiter sharing one toggle-handshake SDRAM read port
//            between several ROM clients; returns 64-bit lines per client.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sdr_req_arbiter #(
  parameter int NUM_CLIENTS = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CLIENTS-1:0]    client_req,
  output logic [NUM_CLIENTS-1:0]    client_ack,
  input  logic [NUM_CLIENTS*27-1:0] client_addr,
  output logic [NUM_CLIENTS*64-1:0] client_data,
  output logic [26:0]               sdr_addr,
  output logic                      sdr_req,
  input  logic                      sdr_ack,
  input  logic [63:0]               sdr_data
);

  localparam int            IW         = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [IW:0]   C_NUM      = (IW+1)'(NUM_CLIENTS);
  localparam logic [IW-1:0] C_LAST_RST = IW'(NUM_CLIENTS - 1);
  localparam logic [26:0]   C_ALIGN    = 27'h7FF_FFF8;

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]               r_state;
  logic [IW-1:0]            r_last;
  logic [IW-1:0]            r_grant;
  logic [NUM_CLIENTS-1:0]   r_ack;
  logic [NUM_CLIENTS*64-1:0] r_data;
  logic [26:0]              r_sdr_addr;
  logic                     r_sdr_req;

  logic [NUM_CLIENTS-1:0]   w_pend;
  logic                     w_found;
  logic [IW-1:0]            w_grant;
  logic [IW:0]              w_idx;
  logic [26:0]              w_sel_addr;
  logic                     w_done;

  assign w_pend = client_req ^ r_ack;
  assign w_done = (r_state == ST_WAIT) && (sdr_ack == r_sdr_req);

  // Scan upward from last+1 (wrapping) so the most recently served client
  // is always considered last.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      w_idx = {1'b0, r_last} + (IW+1)'(k);
      if (w_idx >= C_NUM) begin
        w_idx = w_idx - C_NUM;
      end
      if (!w_found && w_pend[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[IW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_addr = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (w_grant == IW'(i)) begin
        w_sel_addr = client_addr[27*i +: 27];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_SYNC;
      r_last     <= C_LAST_RST;
      r_grant    <= '0;
      r_sdr_addr <= '0;
      r_sdr_req  <= 1'b0;
    end else begin
      case (r_state)
        // Drain any completion left over from before reset.
        ST_SYNC: begin
          if (sdr_ack == r_sdr_req) begin
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (w_found) begin
            r_sdr_addr <= w_sel_addr & C_ALIGN;
            r_sdr_req  <= ~r_sdr_req;
            r_grant    <= w_grant;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_done) begin
            r_last  <= r_grant;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ack  <= '0;
      r_data <= '0;
    end else if (w_done) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (r_grant == IW'(i)) begin
          r_data[64*i +: 64] <= sdr_data;
          r_ack[i]           <= ~r_ack[i];
        end
      end
    end
  end

  assign client_ack  = r_ack;
  assign client_data = r_data;
  assign sdr_addr    = r_sdr_addr;
  assign sdr_req     = r_sdr_req;

endmodule

`default_nettype wire

// File: tb/tb_sdr_req_arbiter.sv
// ============================================================================
// Module   : tb_sdr_req_arbiter
// Purpose  : Directed and randomised checks of sdr_req_arbiter against a
//            toggle-handshake SDRAM model with programmable latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sdr_req_arbiter;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   client_req;
  logic [N-1:0]   client_ack;
  logic [N*27-1:0] client_addr;
  logic [N*64-1:0] client_data;
  logic [26:0]    sdr_addr;
  logic           sdr_req;
  logic           sdr_ack;
  logic [63:0]    sdr_data;

  int errors = 0;
  int checks = 0;

  // SDRAM model controls
  int          lat_cfg   = 1;
  bit          rand_lat  = 1'b0;
  bit          use_fixed = 1'b0;
  logic [63:0] fixed_data = '0;
  bit          mdl_rst   = 1'b1;
  bit          busy;
  int          cnt;
  logic        last_seen;
  logic [26:0] cap_addr;
  logic        cap_req;

  sdr_req_arbiter #(.NUM_CLIENTS(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .client_req (client_req),
    .client_ack (client_ack),
    .client_addr(client_addr),
    .client_data(client_data),
    .sdr_addr   (sdr_addr),
    .sdr_req    (sdr_req),
    .sdr_ack    (sdr_ack),
    .sdr_data   (sdr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [26:0] a);
    return {5'h15, a, 5'h0A, ~a};
  endfunction

  // SDRAM model: a new sdr_req toggle is acked lat cycles later; lat=1 means
  // the arbiter sees the ack on the very next edge.
  initial begin
    sdr_ack = 1'b0; sdr_data = '0; busy = 1'b0; cnt = 0;
    last_seen = 1'b0; cap_addr = '0; cap_req = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mdl_rst) begin
        sdr_ack = 1'b0; busy = 1'b0; last_seen = 1'b0;
      end else begin
        if (!reset_n) begin
          last_seen = sdr_req;
        end else if (sdr_req !== last_seen) begin
          last_seen = sdr_req;
          busy      = 1'b1;
          cap_addr  = sdr_addr;
          cap_req   = sdr_req;
          cnt       = rand_lat ? int'($urandom_range(1, 20)) : lat_cfg;
        end
        if (busy) begin
          cnt = cnt - 1;
          if (cnt <= 0) begin
            sdr_data = use_fixed ? fixed_data : mem_word(cap_addr);
            sdr_ack  = cap_req;
            busy     = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    mdl_rst = 1'b1; reset_n = 1'b0;
    client_req = '0; client_addr = '0;
    use_fixed = 1'b0; rand_lat = 1'b0; lat_cfg = 1;
    repeat (2) tick();
    reset_n = 1'b1; mdl_rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    mdl_rst = 1'b1; reset_n = 1'b0;
    client_req = '0; client_addr = '0;
    repeat (2) tick();
    checks++; if (client_ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b expected 000", client_ack); end
    checks++; if (client_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", client_data); end
    checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL reset_sdr_req: got %b expected 0", sdr_req); end
    checks++; if (sdr_addr !== 27'h0) begin errors++; $display("FAIL reset_sdr_addr: got %h expected 0", sdr_addr); end
    reset_n = 1'b1; mdl_rst = 1'b0;
    repeat (3) tick();
    checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL idle_no_issue: got %b expected 0", sdr_req); end
    checks++; if (client_ack !== 3'b000) begin errors++; $display("FAIL idle_no_ack: got %b expected 000", client_ack); end
  endtask

  task automatic test_single;
    int n;
    bit ok;
    lat_cfg = 4; use_fixed = 1'b1; fixed_data = 64'hDEADBEEF_CAFEF00D;
    client_addr[27 +: 27] = 27'h0123457;
    client_req[1] = ~client_req[1];
    n = 0; ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      tick(); n++;
      if (client_ack[1] == client_req[1]) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no ack expected ack within 30"); end
    checks++; if (n != 5) begin errors++; $display("FAIL single_latency: got %0d expected 5", n); end
    checks++; if (sdr_addr !== 27'h0123450) begin errors++; $display("FAIL single_sdr_addr: got %h expected 0123450", sdr_addr); end
    checks++; if (client_ack !== 3'b010) begin errors++; $display("FAIL single_ack: got %b expected 010", client_ack); end
    checks++; if (client_data[64 +: 64] !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL single_data1: got %h expected deadbeefcafef00d", client_data[64 +: 64]); end
    checks++; if (client_data[0 +: 64] !== 64'h0 || client_data[128 +: 64] !== 64'h0) begin errors++; $display("FAIL single_other_data: got %h expected 0", client_data); end
    use_fixed = 1'b0;
  endtask

  task automatic test_fastest;
    logic exp_req;
    logic ack0;
    lat_cfg = 1;
    exp_req = ~sdr_req;
    ack0 = client_ack[0];
    client_addr[0 +: 27] = 27'h7ABCDEF;
    client_req[0] = ~client_req[0];
    tick();
    checks++; if (sdr_req !== exp_req) begin errors++; $display("FAIL fast_issue: got %b expected %b", sdr_req, exp_req); end
    checks++; if (client_ack[0] !== ack0) begin errors++; $display("FAIL fast_early_ack: got %b expected %b", client_ack[0], ack0); end
    tick();
    checks++; if (client_ack[0] !== ~ack0) begin errors++; $display("FAIL fast_ack: got %b expected %b", client_ack[0], ~ack0); end
    checks++; if (client_data[0 +: 64] !== mem_word(27'h7ABCDE8)) begin errors++; $display("FAIL fast_data: got %h expected %h", client_data[0 +: 64], mem_word(27'h7ABCDE8)); end
  endtask

  task automatic test_back_to_back;
    int issue_t[8], ack_t[8], who[8];
    logic [26:0] iaddr[8];
    int ni, na;
    logic prev_req;
    logic [N-1:0] prev_ack;
    logic [26:0] exp_a[3];
    do_reset();
    lat_cfg = 2;
    exp_a[0] = 27'h1000000; exp_a[1] = 27'h2000010; exp_a[2] = 27'h3FFFFF8;
    client_addr[0 +: 27]  = 27'h1000001;
    client_addr[27 +: 27] = 27'h2000012;
    client_addr[54 +: 27] = 27'h3FFFFFF;
    client_req = ~client_req;
    ni = 0; na = 0; prev_req = sdr_req; prev_ack = client_ack;
    for (int t = 1; t <= 40 && na < 3; t++) begin
      tick();
      if (sdr_req !== prev_req && ni < 8) begin issue_t[ni] = t; iaddr[ni] = sdr_addr; ni++; end
      for (int i = 0; i < N; i++) begin
        if (client_ack[i] !== prev_ack[i] && na < 8) begin who[na] = i; ack_t[na] = t; na++; end
      end
      prev_req = sdr_req; prev_ack = client_ack;
    end
    checks++; if (ni != 3 || na != 3) begin errors++; $display("FAIL b2b_counts: got issues=%0d acks=%0d expected 3 and 3", ni, na); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (who[k] != k) begin errors++; $display("FAIL b2b_order%0d: got client %0d expected %0d", k, who[k], k); end
        checks++; if (issue_t[k] != 1 + 3*k) begin errors++; $display("FAIL b2b_issue_t%0d: got %0d expected %0d", k, issue_t[k], 1 + 3*k); end
        checks++; if (ack_t[k] != 3 + 3*k) begin errors++; $display("FAIL b2b_ack_t%0d: got %0d expected %0d", k, ack_t[k], 3 + 3*k); end
        checks++; if (iaddr[k] !== exp_a[k]) begin errors++; $display("FAIL b2b_addr%0d: got %h expected %h", k, iaddr[k], exp_a[k]); end
        checks++; if (client_data[64*k +: 64] !== mem_word(exp_a[k])) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, client_data[64*k +: 64], mem_word(exp_a[k])); end
      end
    end
  endtask

  task automatic test_fairness;
    int who[8];
    int na, reissue;
    logic [N-1:0] prev_ack;
    do_reset();
    lat_cfg = 2;
    client_addr[0 +: 27] = 27'h0000100; client_addr[27 +: 27] = 27'h0000200; client_addr[54 +: 27] = 27'h0000300;
    client_req = ~client_req;
    na = 0; reissue = 1; prev_ack = client_ack;
    for (int t = 0; t < 60 && na < 4; t++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (client_ack[i] !== prev_ack[i] && na < 8) begin
          who[na] = i; na++;
          if (i == 0 && reissue > 0) begin client_req[0] = ~client_req[0]; reissue--; end
        end
      end
      prev_ack = client_ack;
    end
    checks++; if (na != 4) begin errors++; $display("FAIL fair_count: got %0d expected 4", na); end
    else begin
      checks++; if (who[0] != 0) begin errors++; $display("FAIL fair_0: got %0d expected 0", who[0]); end
      checks++; if (who[1] != 1) begin errors++; $display("FAIL fair_1: got %0d expected 1", who[1]); end
      checks++; if (who[2] != 2) begin errors++; $display("FAIL fair_2: got %0d expected 2", who[2]); end
      checks++; if (who[3] != 0) begin errors++; $display("FAIL fair_3: got %0d expected 0", who[3]); end
    end
  endtask

  task automatic test_reset_wait;
    bit ok;
    int changes;
    do_reset();
    lat_cfg = 12;
    client_addr[54 +: 27] = 27'h0ABCDE5;
    client_req[2] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (sdr_req === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rw_issue: got sdr_req=%b expected 1", sdr_req); end
    repeat (3) tick();
    reset_n = 1'b0; client_req = '0;
    repeat (2) tick();
    checks++; if (client_ack !== 3'b000) begin errors++; $display("FAIL rw_ack: got %b expected 000", client_ack); end
    checks++; if (client_data !== '0) begin errors++; $display("FAIL rw_data: got %h expected 0", client_data); end
    checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL rw_sdr_req: got %b expected 0", sdr_req); end
    checks++; if (sdr_addr !== 27'h0) begin errors++; $display("FAIL rw_sdr_addr: got %h expected 0", sdr_addr); end
    // Stale ack lands while reset is held
    changes = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (client_ack !== 3'b000) changes++;
    end
    reset_n = 1'b1;
    repeat (3) tick();
    lat_cfg = 3;
    client_addr[0 +: 27] = 27'h0000ABC;
    client_req[0] = 1'b1;
    repeat (4) tick();
    if (client_ack !== 3'b000) changes++;
    checks++; if (changes != 0) begin errors++; $display("FAIL rw_spurious_ack: got %0d toggles expected 0", changes); end
    checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL rw_sync_hold: got sdr_req=%b expected 0", sdr_req); end
    mdl_rst = 1'b1;
    tick();
    mdl_rst = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (client_ack[0] === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || client_ack !== 3'b001) begin errors++; $display("FAIL rw_after: got ack=%b expected 001", client_ack); end
    checks++; if (client_data[0 +: 64] !== mem_word(27'h0000AB8)) begin errors++; $display("FAIL rw_after_data: got %h expected %h", client_data[0 +: 64], mem_word(27'h0000AB8)); end
  endtask

  task automatic test_random_stress;
    logic [26:0]  ea[N];
    bit           outst[N];
    logic [N-1:0] prev_ack;
    int issued, done;
    logic [26:0] a;
    do_reset();
    rand_lat = 1'b1;
    issued = 0; done = 0; prev_ack = client_ack;
    for (int i = 0; i < N; i++) begin outst[i] = 1'b0; ea[i] = '0; end
    for (int t = 0; t < 40000 && done < 1000; t++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (client_ack[i] !== prev_ack[i]) begin
          checks++;
          if (!outst[i]) begin
            errors++; $display("FAIL stress_spurious: client %0d got ack toggle expected none", i);
          end else if (client_data[64*i +: 64] !== mem_word(ea[i] & 27'h7FFFFF8)) begin
            errors++; $display("FAIL stress_data: client %0d got %h expected %h", i, client_data[64*i +: 64], mem_word(ea[i] & 27'h7FFFFF8));
          end
          outst[i] = 1'b0; done++;
        end
        if (!outst[i] && issued < 1000 && $urandom_range(0, 2) == 0) begin
          a = 27'($urandom);
          ea[i] = a;
          client_addr[27*i +: 27] = a;
          client_req[i] = ~client_req[i];
          outst[i] = 1'b1; issued++;
        end
      end
      prev_ack = client_ack;
    end
    checks++; if (done != 1000) begin errors++; $display("FAIL stress_count: got %0d completions expected 1000", done); end
    rand_lat = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; client_req = '0; client_addr = '0;
    test_reset();
    test_single();
    test_fastest();
    test_back_to_back();
    test_fairness();
    test_reset_wait();
    test_random_stress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sdr_req_arbiter.md
# sdr_req_arbiter

Round-robin arbiter sharing one toggle-handshake SDRAM read port between several ROM clients (CPU ROM cache, sprite/tile fetchers, sound ROM). Each client presents a toggle request and a 27-bit byte address. The arbiter serialises the requests onto the single SDRAM port and returns the 64-bit line to the granted client with a toggled acknowledge. It sits between the SDRAM controller and all ROM-side consumers.

## Interface

Parameters:
- NUM_CLIENTS, 3, number of requesters (2..8)

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset; one clock, synchronous, active-low
- client_req  input  NUM_CLIENTS  per-client toggle request; pending while client_req[i] != client_ack[i]
- client_ack  output  NUM_CLIENTS  per-client toggle acknowledge
- client_addr  input  NUM_CLIENTS*27  packed byte addresses; client i at [27*i+26:27*i]; held stable while pending
- client_data  output  NUM_CLIENTS*64  packed per-client returned lines; client i at [64*i+63:64*i]
- sdr_addr  output  27  address to SDRAM controller
- sdr_req  output  1  toggle request to SDRAM controller
- sdr_ack  input  1  toggle acknowledge; transaction complete when sdr_ack == sdr_req
- sdr_data  input  64  read data, valid when sdr_ack == sdr_req after a request

## Operation

- State machine: SYNC, IDLE, WAIT.
- SYNC: entered on reset. Stays until sdr_ack == sdr_req, then goes to IDLE. Issues nothing. This discards any completion still in flight from before reset.
- IDLE: pending vector p[i] = client_req[i] ^ client_ack[i].
  - If p == 0, stay in IDLE.
  - Otherwise grant g is the first pending index scanning upward from last+1 modulo NUM_CLIENTS, where last is the most recently served client.
  - On that edge: sdr_addr <= client_addr[g] with bits [2:0] forced to 0 (64-bit aligned); sdr_req <= ~sdr_req; grant register <= g; state -> WAIT.
- WAIT: when sdr_ack == sdr_req, on that edge:
  - client_data[g] <= sdr_data;
  - client_ack[g] <= ~client_ack[g];
  - last <= g;
  - state -> IDLE.
  - Other clients' data and ack hold their values.
- Fairness: a pending client waits at most NUM_CLIENTS-1 foreign transactions before it is granted.
- A client re-toggling client_req while already pending is a protocol violation. Behaviour is undefined and not checked.
- client_addr is sampled only at the grant edge.

## Timing

- Reset values: client_ack = 0, client_data = 0, sdr_req = 0, sdr_addr = 0, last = NUM_CLIENTS-1 (so client 0 wins the first arbitration), state = SYNC.
- Reset mid-WAIT: the transaction is abandoned and no client_ack toggles. After reset the arbiter sits in SYNC until the SDRAM controller (reset alongside it) shows sdr_ack == 0.
- Request latency: a client_req toggle sampled at edge N gives an sdr_req toggle at edge N+1 (when IDLE and granted).
- Completion: sdr_ack matching sdr_req is sampled at edge M; client_ack and client_data update at edge M. The client sees them from M+1.
- Minimum turnaround: client_ack toggles 2 clocks after client_req when sdr_ack returns in one clock.
- Back-to-back: after every completion the arbiter spends exactly one IDLE cycle before the next sdr_req toggle.
- Simultaneous events:
  - A new request arriving in the same cycle as a completion is considered in the following IDLE cycle.
  - The client whose ack is toggling is not pending in that IDLE cycle unless it re-toggles client_req.

## Test plan

- Single client: reset, then client 1 toggles req with addr 0x0123457, SDRAM model acks 4 clocks later with data 0xDEADBEEF_CAFEF00D -> sdr_addr = 0x0123450; client_ack[1] toggles; client_data[1] = 0xDEADBEEF_CAFEF00D; other acks stay 0.
- All three clients toggle req in the same cycle after reset -> service order 0, 1, 2; three sdr_req toggles with one IDLE cycle between each completion and the next issue.
- Fairness: client 0 re-requests immediately after every ack while clients 1 and 2 each have one pending request -> order 0, 1, 2, 0, never 0, 0.
- Reset during WAIT: assert reset_n low with client 2 granted, SDRAM model acks later.
  - No client_ack toggles and all outputs return to their reset values.
  - After reset_n is released, a new client 0 request is served correctly once sdr_ack == sdr_req.
- Variable SDRAM latency of 1..20 clocks, randomised addresses, 1000 requests across all clients -> every returned line matches the model's memory at the aligned address, and every request is acknowledged exactly once.
- Fastest path: ack returned in one clock -> client_req toggled at edge N gives client_ack toggled at edge N+2.
